// File: rtl/bcd_alu_pkg.sv
// Shared types and constants for the serial BCD ALU host front end.
package bcd_alu_pkg;

    localparam int FRAME_BITS = 33;
    localparam int RES_BITS   = 20;

    typedef logic [15:0] bcd_operand_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } host_state_e;

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_host_shreg.sv
// Loadable LSB-first shift register; serial data enters at the MSB and
// leaves at bit 0.
module bcd_host_shreg
    import bcd_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Load wins over shift.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_val;
        end else if (shift) begin
            sr_d = {sin, sr_q[W-1:1]};
        end else begin
            sr_d = sr_q;
        end
    end

    // Register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/bcd_alu_host.sv
// Serial front end for the BCD ALU: sends a 33-bit operand frame, waits,
// then collects the 20-bit result. Define BCD_HOST_CHECK_EN to reject
// operands containing non-BCD digits.
module bcd_alu_host #(
    parameter int N_DIGITS = 4,
    parameter int RES_BITS = 20,
    parameter int RESP_DLY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] op_a,
    input  logic [4*N_DIGITS-1:0] op_b,
    input  logic                  sub,
    output logic                  busy,
    output logic                  done,
    output logic [RES_BITS-1:0]   res,
    output logic                  err,
    output logic                  ser_en,
    output logic                  ser_out,
    input  logic                  ser_in
);
    import bcd_alu_pkg::*;

    localparam int OP_W  = 4 * N_DIGITS;
    localparam int FRM_W = 2 * OP_W + 1;
    localparam logic [5:0] SEND_LAST = 6'(FRM_W - 1);
    localparam logic [5:0] RECV_LAST = 6'(RES_BITS - 1);
    localparam logic [5:0] WAIT_LAST = 6'((RESP_DLY > 0) ? RESP_DLY - 1 : 0);

    host_state_e         state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ser_en_q, ser_en_d;
    logic                ser_out_q, ser_out_d;
    logic [RES_BITS-1:0] res_q, res_d;

    logic                tx_load_s, tx_shift_s, rx_shift_s, bad_s;
    logic [FRM_W-1:0]    frame_s, tx_q;
    logic [RES_BITS-1:0] rx_q;
    logic                tx_unused_s, rx_unused_s;

    assign frame_s = {sub, op_b, op_a};

`ifdef BCD_HOST_CHECK_EN
    // Flag any operand nibble outside 0..9.
    always_comb begin
        bad_s = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!bcd_digit_ok(op_a[4*i +: 4]) || !bcd_digit_ok(op_b[4*i +: 4])) begin
                bad_s = 1'b1;
            end else begin
                bad_s = bad_s;
            end
        end
    end
`else
    assign bad_s = 1'b0;
`endif

    // Bit 0 goes straight to ser_out at acceptance, so the transmitter holds
    // the frame pre-shifted by one and its bit 0 is always the next bit due.
    bcd_host_shreg #(.W(FRM_W)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load_s),
        .shift    (tx_shift_s),
        .sin      (1'b0),
        .load_val ({1'b0, frame_s[FRM_W-1:1]}),
        .q        (tx_q)
    );

    bcd_host_shreg #(.W(RES_BITS)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .shift    (rx_shift_s),
        .sin      (ser_in),
        .load_val ('0),
        .q        (rx_q)
    );

    assign tx_unused_s = ^tx_q[FRM_W-1:1];
    assign rx_unused_s = rx_q[0];

    // Transaction sequencing; cnt_q counts down the remaining cycles of a phase.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        ser_en_d   = 1'b0;
        ser_out_d  = 1'b0;
        res_d      = res_q;
        tx_load_s  = 1'b0;
        tx_shift_s = 1'b0;
        rx_shift_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    err_d  = bad_s;
                    if (bad_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_SEND;
                        cnt_d     = SEND_LAST;
                        ser_en_d  = 1'b1;
                        ser_out_d = frame_s[0];
                        tx_load_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cnt_q == 6'd0) begin
                    state_d = (RESP_DLY > 0) ? ST_WAIT : ST_RECV;
                    cnt_d   = (RESP_DLY > 0) ? WAIT_LAST : RECV_LAST;
                end else begin
                    cnt_d      = cnt_q - 6'd1;
                    ser_en_d   = 1'b1;
                    ser_out_d  = tx_q[0];
                    tx_shift_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_RECV;
                    cnt_d   = RECV_LAST;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_RECV: begin
                rx_shift_s = 1'b1;
                if (cnt_q == 6'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    res_d   = {ser_in, rx_q[RES_BITS-1:1]};
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ser_en_q  <= 1'b0;
            ser_out_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ser_en_q  <= ser_en_d;
            ser_out_q <= ser_out_d;
            res_q     <= res_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign ser_en  = ser_en_q;
    assign ser_out = ser_out_q;
    assign res     = res_q;

endmodule
